// File: rtl/fetch_stage.sv
// Instruction-fetch stage plus IF/ID pipeline register.
// Holds PC_F and runs a req/ack handshake with a variable-latency instruction memory.
// A decode-stage redirect (branch or jump) either retargets PC_F directly or, if a request is
// still in flight, is remembered in pending_q until the stale word arrives and is dropped.
// Ports:
//   CLK, RST           clock, asynchronous active-low reset
//   Stall_F, Stall_D   hazard-unit stalls (no new request / hold IF/ID)
//   PCSrc_D, Jump_D    decode redirect; jump wins over branch
//   PCBranch_D, PCJump_D  redirect targets
//   IMem_Req/Addr      fetch request and address (stable until ack)
//   IMem_Ack/RData     memory acknowledge and same-cycle instruction word
//   Instr_D, PCPlus4_D, Valid_D  IF/ID register contents (bubble = all zero)
//   Fetch_Busy         a memory wait is in progress
module fetch_stage #(
  parameter int unsigned            datasize = 32,
  parameter logic [datasize-1:0]    RESET_PC = '0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                Stall_F,
  input  logic                Stall_D,
  input  logic                PCSrc_D,
  input  logic                Jump_D,
  input  logic [datasize-1:0] PCBranch_D,
  input  logic [datasize-1:0] PCJump_D,
  output logic                IMem_Req,
  output logic [datasize-1:0] IMem_Addr,
  input  logic                IMem_Ack,
  input  logic [datasize-1:0] IMem_RData,
  output logic [datasize-1:0] Instr_D,
  output logic [datasize-1:0] PCPlus4_D,
  output logic                Valid_D,
  output logic                Fetch_Busy
);

  typedef enum logic [1:0] {StIdle, StWait, StDrop, StHold} state_e;

  state_e              state_q, state_d;
  logic [datasize-1:0] pc_q, pc_d;
  logic [datasize-1:0] pending_q, pending_d;
  logic [datasize-1:0] skid_q, skid_d;
  logic [datasize-1:0] instr_q, instr_d;
  logic [datasize-1:0] pcplus4_q, pcplus4_d;
  logic                valid_q, valid_d;

  logic                redirect;
  logic [datasize-1:0] target;
  logic [datasize-1:0] pc_plus4;
  logic                req;
  logic                deliver;
  logic [datasize-1:0] deliver_word;

  always_comb begin
    redirect = PCSrc_D | Jump_D;
    target   = Jump_D ? PCJump_D : PCBranch_D;
    // Wraps modulo 2^datasize.
    pc_plus4 = pc_q + datasize'(4);
  end

  // Next-state, PC and request logic.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pending_d    = pending_q;
    skid_d       = skid_q;
    req          = 1'b0;
    deliver      = 1'b0;
    deliver_word = IMem_RData;

    unique case (state_q)
      StIdle: begin
        req = ~Stall_F & ~redirect;
        if (redirect) begin
          pc_d = target;
        end else if (req && IMem_Ack) begin
          if (Stall_D) begin
            skid_d  = IMem_RData;
            state_d = StHold;
          end else begin
            deliver = 1'b1;
          end
        end else if (req) begin
          state_d = StWait;
        end
      end
      StWait: begin
        req = 1'b1;
        if (IMem_Ack) begin
          if (redirect) begin
            pc_d    = target;
            state_d = StIdle;
          end else if (!Stall_D) begin
            deliver = 1'b1;
            state_d = StIdle;
          end else begin
            skid_d  = IMem_RData;
            state_d = StHold;
          end
        end else if (redirect) begin
          pending_d = target;
          state_d   = StDrop;
        end
      end
      StDrop: begin
        // Keep the stale request on the bus until the memory completes it.
        req = 1'b1;
        if (IMem_Ack) begin
          pc_d    = redirect ? target : pending_q;
          state_d = StIdle;
        end else if (redirect) begin
          pending_d = target;
        end
      end
      StHold: begin
        if (redirect) begin
          pc_d    = target;
          state_d = StIdle;
        end else if (!Stall_D) begin
          deliver      = 1'b1;
          deliver_word = skid_q;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (deliver) pc_d = pc_plus4;
  end

  // IF/ID register: redirect flush beats stall, stall beats load, otherwise a bubble.
  always_comb begin
    instr_d   = instr_q;
    pcplus4_d = pcplus4_q;
    valid_d   = valid_q;
    if (redirect) begin
      instr_d   = '0;
      pcplus4_d = '0;
      valid_d   = 1'b0;
    end else if (!Stall_D) begin
      if (deliver) begin
        instr_d   = deliver_word;
        pcplus4_d = pc_plus4;
        valid_d   = 1'b1;
      end else begin
        instr_d   = '0;
        pcplus4_d = '0;
        valid_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      pending_q <= '0;
      skid_q    <= '0;
      instr_q   <= '0;
      pcplus4_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pending_q <= pending_d;
      skid_q    <= skid_d;
      instr_q   <= instr_d;
      pcplus4_q <= pcplus4_d;
      valid_q   <= valid_d;
    end
  end

  assign IMem_Req   = req;
  assign IMem_Addr  = pc_q;
  assign Instr_D    = instr_q;
  assign PCPlus4_D  = pcplus4_q;
  assign Valid_D    = valid_q;
  assign Fetch_Busy = (state_q == StWait) || (state_q == StDrop);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a transaction-level model (outstanding fetch / doomed fetch / skid word)
// predicts every cycle, plus literal expectations from the directed scenarios.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_f = 1'b0, stall_d = 1'b0, pcsrc = 1'b0, jump = 1'b0;
  logic [31:0] pcbranch = '0, pcjump = '0;
  logic        ack = 1'b0;
  logic [31:0] rdata = '0;
  logic        req;
  logic [31:0] addr, instr, pc4;
  logic        valid, busy;

  logic        req1, valid1, busy1;
  logic [31:0] addr1, instr1, pc41, rdata1;

  int checks = 0;
  int failures = 0;
  int lat = 0;
  int wait_cnt = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h1234, a[15:0]};
  endfunction

  fetch_stage dut (
    .CLK(clk), .RST(rst_n), .Stall_F(stall_f), .Stall_D(stall_d), .PCSrc_D(pcsrc),
    .Jump_D(jump), .PCBranch_D(pcbranch), .PCJump_D(pcjump), .IMem_Req(req),
    .IMem_Addr(addr), .IMem_Ack(ack), .IMem_RData(rdata), .Instr_D(instr),
    .PCPlus4_D(pc4), .Valid_D(valid), .Fetch_Busy(busy)
  );

  // Second instance: wrap-around reset PC with a zero-wait memory.
  assign rdata1 = mem_word(addr1);
  fetch_stage #(.datasize(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .CLK(clk), .RST(rst_n), .Stall_F(1'b0), .Stall_D(1'b0), .PCSrc_D(1'b0),
    .Jump_D(1'b0), .PCBranch_D(32'h0), .PCJump_D(32'h0), .IMem_Req(req1),
    .IMem_Addr(addr1), .IMem_Ack(req1), .IMem_RData(rdata1), .Instr_D(instr1),
    .PCPlus4_D(pc41), .Valid_D(valid1), .Fetch_Busy(busy1)
  );

  // Model state.
  logic [31:0] m_pc, m_tgt, m_skid, m_instr, m_pc4;
  bit          m_out, m_doomed, m_skid_v, m_valid, m_req;

  task automatic model_reset();
    m_pc = 32'h0; m_tgt = '0; m_skid = '0; m_instr = '0; m_pc4 = '0;
    m_out = 0; m_doomed = 0; m_skid_v = 0; m_valid = 0; m_req = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare DUT outputs against the model for the current cycle.
  task automatic check_cycle();
    bit redir;
    redir = pcsrc | jump;
    // A request is on the bus if one is in flight, or if nothing blocks a fresh one.
    m_req = m_out | (!m_skid_v && !stall_f && !redir);
    chk("req", {31'b0, req}, {31'b0, m_req});
    if (m_req) chk("addr", addr, m_pc);
    chk("busy", {31'b0, busy}, {31'b0, m_out});
    chk("instr_d", instr, m_instr);
    chk("pcplus4_d", pc4, m_pc4);
    chk("valid_d", {31'b0, valid}, {31'b0, m_valid});
  endtask

  task automatic model_update();
    bit          redir, dlv;
    logic [31:0] tgt, word;
    redir = pcsrc | jump;
    tgt   = jump ? pcjump : pcbranch;
    dlv   = 0;
    word  = '0;
    if (m_skid_v) begin
      if (redir) begin
        m_skid_v = 0; m_pc = tgt;
      end else if (!stall_d) begin
        dlv = 1; word = m_skid; m_skid_v = 0;
      end
    end else if (m_out && m_doomed) begin
      if (ack) begin
        m_pc = redir ? tgt : m_tgt; m_out = 0; m_doomed = 0;
      end else if (redir) begin
        m_tgt = tgt;
      end
    end else if (m_req) begin
      if (ack) begin
        m_out = 0;
        if (redir) m_pc = tgt;
        else if (!stall_d) begin dlv = 1; word = rdata; end
        else begin m_skid_v = 1; m_skid = rdata; end
      end else begin
        m_out = 1;
        if (redir) begin m_doomed = 1; m_tgt = tgt; end
      end
    end else if (redir) begin
      m_pc = tgt;
    end
    if (redir) begin
      m_instr = '0; m_pc4 = '0; m_valid = 0;
    end else if (!stall_d) begin
      m_instr = dlv ? word : '0;
      m_pc4   = dlv ? m_pc + 32'd4 : '0;
      m_valid = dlv;
    end
    if (dlv) m_pc = m_pc + 32'd4;
  endtask

  // One clock cycle: inputs already set at the preceding negedge.
  task automatic cycle();
    bit req_s;
    #1;
    ack   = req && (wait_cnt >= lat);
    rdata = ack ? mem_word(addr) : 32'hDEAD_BEEF;
    #1;
    check_cycle();
    req_s = req;
    @(posedge clk);
    model_update();
    wait_cnt = (req_s && !ack) ? wait_cnt + 1 : 0;
    @(negedge clk);
  endtask

  logic [7:0] vec [18] = '{8'h90, 8'h91, 8'h92, 8'h01, 8'h04, 8'h06, 8'h90, 8'h04, 8'h00,
                           8'h90, 8'h02, 8'h08, 8'h0C, 8'h00, 8'h00, 8'h10, 8'h10, 8'h00};

  initial begin
    int bcount;
    model_reset();
    repeat (2) @(negedge clk);
    // Reset state.
    #1;
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc4", pc4, 32'h0);
    chk("rst_valid", {31'b0, valid}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_req", {31'b0, req}, 32'h1);
    chk("rst_addr", addr, 32'h0);
    chk("wrap_rst_addr", addr1, 32'hFFFF_FFFC);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero-wait streaming.
    lat = 0;
    cycle();
    chk("s1_addr1", addr, 32'h4);
    chk("s1_pc4_1", pc4, 32'h4);
    chk("s1_instr_1", instr, 32'h1234_0000);
    chk("s1_valid_1", {31'b0, valid}, 32'h1);
    chk("wrap_pc4", pc41, 32'h0);
    chk("wrap_addr2", addr1, 32'h0);
    chk("wrap_instr", instr1, 32'hEDC8_FFFC);
    chk("wrap_valid", {31'b0, valid1}, 32'h1);
    cycle();
    chk("s1_addr2", addr, 32'h8);
    chk("s1_pc4_2", pc4, 32'h8);
    cycle();
    chk("s1_pc4_3", pc4, 32'hC);
    cycle();

    // Three wait cycles at 0x10.
    chk("s2_addr", addr, 32'h10);
    lat = 3;
    bcount = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (busy) begin
        bcount++;
        chk("s2_valid_wait", {31'b0, valid}, 32'h0);
      end
    end
    chk("s2_busy_cycles", bcount, 32'd3);
    chk("s2_pc4", pc4, 32'h14);
    chk("s2_instr", instr, 32'h1224_0010);

    // Ack while Stall_D: skid, then deliver.
    lat = 0;
    stall_d = 1'b1;
    cycle();
    chk("s3_req_hold", {31'b0, req}, 32'h0);
    chk("s3_pc4_held1", pc4, 32'h14);
    cycle();
    chk("s3_pc4_held2", pc4, 32'h14);
    stall_d = 1'b0;
    cycle();
    chk("s3_pc4", pc4, 32'h18);
    chk("s3_instr", instr, 32'h1220_0014);

    // Jump during a wait at 0x20.
    cycle();
    cycle();
    chk("s4_addr", addr, 32'h20);
    lat = 3;
    cycle();
    jump = 1'b1; pcjump = 32'h400;
    cycle();
    jump = 1'b0;
    chk("s4_busy_drop", {31'b0, busy}, 32'h1);
    chk("s4_valid_drop", {31'b0, valid}, 32'h0);
    cycle();
    cycle();
    chk("s4_addr_target", addr, 32'h400);
    chk("s4_valid_after", {31'b0, valid}, 32'h0);
    lat = 0;
    cycle();
    chk("s4_pc4", pc4, 32'h404);

    // Branch and jump together under Stall_D.
    stall_d = 1'b1; pcsrc = 1'b1; jump = 1'b1;
    pcbranch = 32'h100; pcjump = 32'h200;
    cycle();
    stall_d = 1'b0; pcsrc = 1'b0; jump = 1'b0;
    chk("s5_valid", {31'b0, valid}, 32'h0);
    chk("s5_pc4", pc4, 32'h0);
    chk("s5_instr", instr, 32'h0);
    chk("s5_addr", addr, 32'h200);
    cycle();
    chk("s5_pc4_next", pc4, 32'h204);

    // Stall_F blocks new requests.
    stall_f = 1'b1;
    cycle();
    cycle();
    stall_f = 1'b0;
    chk("s6_pc4_bubble", pc4, 32'h0);

    // Reset in the middle of a wait.
    lat = 5;
    cycle();
    cycle();
    rst_n = 1'b0;
    #1;
    chk("s7_busy", {31'b0, busy}, 32'h0);
    chk("s7_addr", addr, 32'h0);
    chk("s7_valid", {31'b0, valid}, 32'h0);
    model_reset();
    wait_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Directed mixed vectors.
    for (int i = 0; i < 18; i++) begin
      lat      = int'(vec[i][7:4]);
      stall_f  = vec[i][3];
      stall_d  = vec[i][2];
      pcsrc    = vec[i][1];
      jump     = vec[i][0];
      pcbranch = 32'h1000 + 32'(i * 8);
      pcjump   = 32'h2000 + 32'(i * 4);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
